// File: rtl/program_counter.sv
// Architectural PC register: loads PCin when PCwrite is 1, otherwise holds.
// Asynchronous active-low reset forces RESET_VECTOR.
module program_counter #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCwrite,
  input  logic [WIDTH-1:0] PCin,
  output logic [WIDTH-1:0] PCout
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // An unknown PCwrite falls through to the else branch, so the PC holds.
  always_comb begin
    pc_d = pc_q;
    if (PCwrite) begin
      pc_d = PCin;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PCout = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed plus randomized checks of program_counter against a reference model.
// The model tracks the most recent address written since reset.
module tb_program_counter;

  localparam int unsigned WIDTH = 16;
  localparam logic [WIDTH-1:0] RV = 16'h0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             PCwrite;
  logic [WIDTH-1:0] PCin;
  logic [WIDTH-1:0] PCout;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_pc;

  program_counter #(.WIDTH(WIDTH), .RESET_VECTOR(RV)) dut (
    .clk(clk),
    .rst(rst),
    .PCwrite(PCwrite),
    .PCin(PCin),
    .PCout(PCout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    checks++;
    assert (PCout === exp_pc) else begin
      errors++;
      $error("FAIL %s: PCout=%h expected=%h", tag, PCout, exp_pc);
    end
  endtask

  // The model is the last address committed since reset.
  // Inputs are stable at the edge, so sampling them here is safe.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst === 1'b1 && PCwrite === 1'b1) exp_pc = PCin;
    #1;
    check(tag);
    $display("t=%0t %s rst=%b we=%b in=%h out=%h exp=%h",
             $time, tag, rst, PCwrite, PCin, PCout, exp_pc);
  endtask

  task automatic drive(input logic we, input logic [WIDTH-1:0] addr);
    #3;
    PCwrite = we;
    PCin    = addr;
  endtask

  initial begin
    logic [WIDTH-1:0] seq [5];
    logic [WIDTH-1:0] ext [3];
    seq = '{16'd2, 16'd4, 16'd6, 16'd3, 16'd1};
    ext = '{16'hFFFF, 16'h0000, 16'h8000};

    // Reset held across edges with a pending load
    rst = 1'b0; PCwrite = 1'b1; PCin = 16'h1234; exp_pc = RV;
    #2;
    check("reset_initial");
    for (int i = 0; i < 3; i++) tick("reset_hold");
    #2;
    rst = 1'b1;
    #1;
    check("reset_release_midcycle");
    tick("first_load_1234");

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq[i]);
      tick("seq_load");
    end

    drive(1'b1, 16'd8);
    tick("stall_preload");
    drive(1'b0, 16'd10);
    tick("stall_10");
    drive(1'b0, 16'd12);
    tick("stall_12");
    drive(1'b1, 16'd5);
    tick("stall_resume_5");

    // Unknown enable straight after a reset release
    #3;
    rst = 1'b0;
    exp_pc = RV;
    #1;
    check("reset_before_x");
    PCwrite = 1'bx; PCin = 16'h00FF;
    #1;
    rst = 1'b1;
    tick("x_enable_1");
    tick("x_enable_2");

    drive(1'b1, 16'hFFFE);
    tick("load_fffe");
    #3;
    rst = 1'b0;
    exp_pc = RV;
    #1;
    check("async_reset_midrun");
    PCwrite = 1'b1; PCin = 16'h0002;
    #1;
    rst = 1'b1;
    tick("post_reset_load_2");

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ext[i]);
      tick("width_extreme");
    end

    // Random loads, stalls and occasional mid-cycle resets
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), WIDTH'($urandom));
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b0;
        exp_pc = RV;
        #1;
        check("rand_async_reset");
        rst = 1'b1;
      end
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
